// File: rtl/interrupt_sequencer.sv
// Sequences external interrupt entry: waits for a safe point, drains the pipeline,
// pushes PC/flags through the data-memory port, fetches the vector and redirects.
module interrupt_sequencer #(
  parameter int unsigned         PC_WIDTH     = 32,
  parameter int unsigned         DRAIN_CYCLES = 4,
  parameter logic [PC_WIDTH-1:0] VECTOR_ADDR  = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                int_in,
  input  logic                safe_point,
  input  logic [PC_WIDTH-1:0] pc_in,
  input  logic [2:0]          flags_in,
  input  logic [PC_WIDTH-1:0] sp_in,
  input  logic                rti_done,
  input  logic                mem_ready,
  input  logic [15:0]         mem_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [PC_WIDTH-1:0] mem_addr,
  output logic [15:0]         mem_wdata,
  output logic                sp_dec,
  output logic                freeze_fetch,
  output logic                flush,
  output logic                pc_load,
  output logic [PC_WIDTH-1:0] pc_target,
  output logic                ack,
  output logic                busy
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_SAFE,
    DRAIN,
    PUSH_PCH,
    PUSH_PCL,
    PUSH_FLG,
    RD_VH,
    RD_VL,
    JUMP
  } state_t;

  state_t              state_q, state_d;
  logic                int_d_q;
  logic                pending_q, pending_d;
  logic                in_service_q, in_service_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PC_WIDTH-1:0] pc_cap_q, pc_cap_d;
  logic [2:0]          flg_cap_q, flg_cap_d;
  logic [PC_WIDTH-1:0] a_cap_q, a_cap_d;
  logic [15:0]         vh_q, vh_d;
  logic [PC_WIDTH-1:0] pc_target_q, pc_target_d;

  logic                evt;
  logic [31:0]         pcWide;

  assign evt    = int_in & ~int_d_q;
  assign pcWide = 32'(pc_cap_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      int_d_q      <= 1'b0;
      pending_q    <= 1'b0;
      in_service_q <= 1'b0;
      cnt_q        <= '0;
      pc_cap_q     <= '0;
      flg_cap_q    <= '0;
      a_cap_q      <= '0;
      vh_q         <= '0;
      pc_target_q  <= '0;
    end else begin
      state_q      <= state_d;
      int_d_q      <= int_in;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      cnt_q        <= cnt_d;
      pc_cap_q     <= pc_cap_d;
      flg_cap_q    <= flg_cap_d;
      a_cap_q      <= a_cap_d;
      vh_q         <= vh_d;
      pc_target_q  <= pc_target_d;
    end
  end

  // Every memory state holds its request until mem_ready, then advances.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | evt;
    in_service_d = in_service_q & ~rti_done;
    cnt_d        = cnt_q;
    pc_cap_d     = pc_cap_q;
    flg_cap_d    = flg_cap_q;
    a_cap_d      = a_cap_q;
    vh_d         = vh_q;
    pc_target_d  = pc_target_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    sp_dec       = 1'b0;
    freeze_fetch = 1'b0;
    flush        = 1'b0;
    pc_load      = 1'b0;
    ack          = 1'b0;

    case (state_q)
      IDLE: begin
        if ((pending_q || evt) && !in_service_q) begin
          state_d   = WAIT_SAFE;
          pending_d = 1'b0;
        end
      end
      WAIT_SAFE: begin
        freeze_fetch = 1'b1;
        if (safe_point) begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        freeze_fetch = 1'b1;
        if (cnt_q == '0) begin
          pc_cap_d  = pc_in;
          flg_cap_d = flags_in;
          a_cap_d   = sp_in;
          state_d   = PUSH_PCH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PUSH_PCH: begin
        freeze_fetch = 1'b1;
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_addr     = a_cap_q;
        mem_wdata    = pcWide[31:16];
        if (mem_ready) begin
          sp_dec  = 1'b1;
          state_d = PUSH_PCL;
        end
      end
      PUSH_PCL: begin
        freeze_fetch = 1'b1;
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_addr     = a_cap_q - PC_WIDTH'(1);
        mem_wdata    = pcWide[15:0];
        if (mem_ready) begin
          sp_dec  = 1'b1;
          state_d = PUSH_FLG;
        end
      end
      PUSH_FLG: begin
        freeze_fetch = 1'b1;
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_addr     = a_cap_q - PC_WIDTH'(2);
        mem_wdata    = {13'b0, flg_cap_q};
        if (mem_ready) begin
          sp_dec  = 1'b1;
          state_d = RD_VH;
        end
      end
      RD_VH: begin
        freeze_fetch = 1'b1;
        mem_req      = 1'b1;
        mem_addr     = VECTOR_ADDR;
        if (mem_ready) begin
          vh_d    = mem_rdata;
          state_d = RD_VL;
        end
      end
      RD_VL: begin
        freeze_fetch = 1'b1;
        mem_req      = 1'b1;
        mem_addr     = VECTOR_ADDR + PC_WIDTH'(1);
        if (mem_ready) begin
          pc_target_d = PC_WIDTH'({vh_q, mem_rdata});
          state_d     = JUMP;
        end
      end
      JUMP: begin
        pc_load      = 1'b1;
        flush        = 1'b1;
        ack          = 1'b1;
        in_service_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pc_target = pc_target_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: directed entries push expected memory
// writes and acks into a queue; a monitor pops and compares as the DUT presents them.
module tb_interrupt_sequencer;

  logic        clk;
  logic        reset;
  logic        int_in;
  logic        safe_point;
  logic [31:0] pc_in;
  logic [2:0]  flags_in;
  logic [31:0] sp_in;
  logic        rti_done;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        sp_dec;
  logic        freeze_fetch;
  logic        flush;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        ack;
  logic        busy;

  logic [15:0] vecHi;
  logic [15:0] vecLo;
  logic [87:0] allOuts;

  typedef struct {
    logic        isAck;
    logic [31:0] addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t expQ[$];
  exp_t monItem;
  int   checks;
  int   failures;
  int   cyc;
  int   spDecCount;

  interrupt_sequencer #(
    .PC_WIDTH    (32),
    .DRAIN_CYCLES(4),
    .VECTOR_ADDR (32'd0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .int_in      (int_in),
    .safe_point  (safe_point),
    .pc_in       (pc_in),
    .flags_in    (flags_in),
    .sp_in       (sp_in),
    .rti_done    (rti_done),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .sp_dec      (sp_dec),
    .freeze_fetch(freeze_fetch),
    .flush       (flush),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .ack         (ack),
    .busy        (busy)
  );

  assign mem_rdata = (mem_addr == 32'd0) ? vecHi : (mem_addr == 32'd1) ? vecLo : 16'hDEAD;
  assign allOuts   = {mem_req, mem_we, mem_addr, mem_wdata, sp_dec, freeze_fetch,
                      flush, pc_load, pc_target, ack, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic flagFail(input string name, input logic [127:0] actual);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=%0h required=none", name, actual);
  endtask

  // Produces a fresh rising edge on int_in; n is the cycle count just before the sampling edge.
  task automatic applyStimulus(input logic withRti, output int n);
    @(posedge clk); #1;
    int_in = 1'b0;
    @(posedge clk); #1;
    int_in   = 1'b1;
    rti_done = withRti;
    n        = cyc;
    @(posedge clk); #1;
    rti_done = 1'b0;
  endtask

  task automatic expectEntry(input logic [31:0] pc, input logic [2:0] fl,
                             input logic [31:0] sp, input logic [31:0] target,
                             input int ackCyc);
    exp_t e;
    e = '{isAck: 1'b0, addr: sp, data: pc[31:16], cyc: 0};
    expQ.push_back(e);
    e = '{isAck: 1'b0, addr: sp - 32'd1, data: pc[15:0], cyc: 0};
    expQ.push_back(e);
    e = '{isAck: 1'b0, addr: sp - 32'd2, data: {13'b0, fl}, cyc: 0};
    expQ.push_back(e);
    e = '{isAck: 1'b1, addr: target, data: 16'h0, cyc: ackCyc};
    expQ.push_back(e);
  endtask

  task automatic waitIdle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (expQ.size() == 0 && !busy) break;
    end
    if (i == budget) begin
      flagFail("timeout waiting for sequence end", 128'(expQ.size()));
      expQ.delete();
    end
  endtask

  task automatic pulseRti();
    @(posedge clk); #1;
    rti_done = 1'b1;
    @(posedge clk); #1;
    rti_done = 1'b0;
  endtask

  task automatic expectQuiet(input string name, input int nCycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < nCycles; i++) begin
      @(negedge clk);
      seen = seen | busy | mem_req | sp_dec;
    end
    checkOutput(name, 128'(seen), 128'(1'b0));
  endtask

  // Monitor: pops one expectation per completed write and per ack cycle.
  initial begin
    spDecCount = 0;
    forever begin
      @(negedge clk);
      if (mem_req && mem_we && mem_ready) begin
        if (expQ.size() == 0 || expQ[0].isAck) begin
          flagFail("unexpected write", 128'({mem_addr, mem_wdata}));
        end else begin
          monItem = expQ.pop_front();
          checkOutput("push addr/data/sp_dec", 128'({mem_addr, mem_wdata, sp_dec}),
                      128'({monItem.addr, monItem.data, 1'b1}));
        end
      end else if (sp_dec) begin
        flagFail("stray sp_dec", 128'(mem_addr));
      end
      if (sp_dec) spDecCount++;
      if (ack) begin
        if (expQ.size() == 0 || !expQ[0].isAck) begin
          flagFail("unexpected ack", 128'(pc_target));
        end else begin
          monItem = expQ.pop_front();
          checkOutput("ack target/pc_load/flush/freeze/cycle",
                      128'({pc_target, pc_load, flush, freeze_fetch, 32'(cyc)}),
                      128'({monItem.addr, 1'b1, 1'b1, 1'b0, 32'(monItem.cyc)}));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int m;
    int spBase;
    logic found;

    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    int_in     = 1'b0;
    safe_point = 1'b1;
    pc_in      = 32'h0;
    flags_in   = 3'b000;
    sp_in      = 32'h0;
    rti_done   = 1'b0;
    mem_ready  = 1'b1;
    vecHi      = 16'h0000;
    vecLo      = 16'h0000;

    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      int_in = ~int_in;
      @(negedge clk);
      checkOutput("outputs during reset", 128'(allOuts), 128'(0));
    end
    @(posedge clk); #1;
    int_in = 1'b0;
    reset  = 1'b1;
    repeat (2) @(posedge clk);

    // Minimum-latency entry with the documented stack/vector values.
    $display("[TB] full entry, minimum latency");
    pc_in    = 32'h0001_2345;
    flags_in = 3'b101;
    sp_in    = 32'h0000_03FF;
    vecHi    = 16'h0000;
    vecLo    = 16'h0200;
    spBase   = spDecCount;
    applyStimulus(1'b0, n);
    expectEntry(32'h0001_2345, 3'b101, 32'h3FF, 32'h0000_0200, n + 11);
    while (cyc < n + 12) @(negedge clk);
    checkOutput("busy low after ack", 128'(busy), 128'(1'b0));
    waitIdle(40);
    checkOutput("sp_dec pulses full entry", 128'(spDecCount - spBase), 128'(3));
    pulseRti();

    $display("[TB] safe_point held low for 7 cycles");
    pc_in      = 32'h00AB_CDEF;
    flags_in   = 3'b111;
    sp_in      = 32'h0000_1000;
    vecHi      = 16'h8000;
    vecLo      = 16'h0010;
    safe_point = 1'b0;
    applyStimulus(1'b0, n);
    expectEntry(32'h00AB_CDEF, 3'b111, 32'h1000, 32'h8000_0010, n + 18);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checkOutput("freeze, no mem_req while unsafe", 128'({freeze_fetch, mem_req, busy}),
                  128'({1'b1, 1'b0, 1'b1}));
      @(posedge clk); #1;
    end
    safe_point = 1'b1;
    waitIdle(40);
    pulseRti();

    $display("[TB] mem_ready stall in PUSH_PCL");
    pc_in    = 32'hCAFE_0042;
    flags_in = 3'b011;
    sp_in    = 32'h0000_0100;
    vecHi    = 16'h0000;
    vecLo    = 16'h0300;
    spBase   = spDecCount;
    applyStimulus(1'b0, n);
    expectEntry(32'hCAFE_0042, 3'b011, 32'h100, 32'h0000_0300, n + 14);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk); #1;
      if (mem_req && mem_we && mem_addr == 32'h0000_00FF) found = 1'b1;
    end
    checkOutput("reached PUSH_PCL", 128'(found), 128'(1'b1));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stalled push stable", 128'({mem_req, mem_we, mem_addr, mem_wdata, sp_dec}),
                  128'({1'b1, 1'b1, 32'h0000_00FF, 16'h0042, 1'b0}));
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    waitIdle(40);
    checkOutput("sp_dec pulses with stall", 128'(spDecCount - spBase), 128'(3));
    pulseRti();

    $display("[TB] edges during and after service");
    pc_in    = 32'h0000_4000;
    flags_in = 3'b010;
    sp_in    = 32'h0000_0200;
    vecHi    = 16'h0001;
    vecLo    = 16'h0000;
    spBase   = spDecCount;
    applyStimulus(1'b0, n);
    expectEntry(32'h0000_4000, 3'b010, 32'h200, 32'h0001_0000, n + 11);
    repeat (2) @(posedge clk);
    #1 int_in = 1'b0;
    @(posedge clk); #1;
    int_in = 1'b1;
    waitIdle(40);
    expectQuiet("no nesting before rti (2nd edge)", 5);
    @(posedge clk); #1;
    int_in = 1'b0;
    @(posedge clk); #1;
    int_in = 1'b1;
    expectQuiet("no nesting before rti (3rd edge)", 5);
    @(posedge clk); #1;
    rti_done = 1'b1;
    m = cyc;
    expectEntry(32'h0000_4000, 3'b010, 32'h200, 32'h0001_0000, m + 12);
    @(posedge clk); #1;
    rti_done = 1'b0;
    waitIdle(40);
    expectQuiet("merged edges give one entry", 5);
    @(posedge clk); #1;
    int_in = 1'b0;
    applyStimulus(1'b1, n);
    expectEntry(32'h0000_4000, 3'b010, 32'h200, 32'h0001_0000, n + 12);
    waitIdle(40);
    checkOutput("sp_dec pulses three entries", 128'(spDecCount - spBase), 128'(9));
    pulseRti();

    $display("[TB] reset during PUSH_PCL with sp wrap");
    pc_in    = 32'h0007_6543;
    flags_in = 3'b000;
    sp_in    = 32'h0000_0000;
    spBase   = spDecCount;
    applyStimulus(1'b0, n);
    monItem = '{isAck: 1'b0, addr: 32'h0, data: 16'h0007, cyc: 0};
    expQ.push_back(monItem);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk); #1;
      if (mem_req && mem_we && mem_addr == 32'hFFFF_FFFF) found = 1'b1;
    end
    mem_ready = 1'b0;
    checkOutput("wrapped PUSH_PCL addr/data", 128'({found, mem_addr, mem_wdata}),
                128'({1'b1, 32'hFFFF_FFFF, 16'h6543}));
    #1 reset = 1'b0;
    #1 checkOutput("outputs after async reset", 128'(allOuts), 128'(0));
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 int_in = 1'b0;
    reset = 1'b1;
    expectQuiet("idle after reset release", 15);
    checkOutput("sp_dec pulses before reset", 128'(spDecCount - spBase), 128'(1));
    checkOutput("scoreboard drained", 128'(expQ.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
